// File: rtl/addr_gen_pipe.sv
// Effective-address generator: base + extended IR offset, queued in a small result FIFO
// with registered head, occupancy and a sticky carry flag.
module addr_gen_pipe #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned OFF_A_W = 6,
  parameter int unsigned OFF_B_W = 9,
  parameter int unsigned OFF_C_W = 11,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     base_sel,
  input  logic [1:0]               off_sel,
  input  logic                     zext,
  input  logic [WIDTH-1:0]         PC,
  input  logic [WIDTH-1:0]         BaseR,
  input  logic [WIDTH-1:0]         IR,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         addr_out,
  output logic                     carry_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrap_seen
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Low w bits of ir, zero- or sign-extended to WIDTH.
  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] ir,
                                              input int unsigned       w,
                                              input logic              z);
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sh;
    mask   = (WIDTH'(1) << w) - WIDTH'(1);
    sh     = ir >> (w - 1);
    extend = ir & mask;
    if (!z && sh[0]) extend = extend | ~mask;
  endfunction

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] ext;
  logic [EW-1:0]    sum;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic [EW-1:0]    head_next;
  logic             accept;
  logic             pop;

  // Address arithmetic on the operands presented this cycle.
  always_comb begin
    base = base_sel ? BaseR : PC;
    case (off_sel)
      2'b01:   ext = extend(IR, OFF_A_W, zext);
      2'b10:   ext = extend(IR, OFF_B_W, zext);
      2'b11:   ext = extend(IR, OFF_C_W, zext);
      default: ext = '0;
    endcase
    sum = EW'(base) + EW'(ext);
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Next occupancy and next head; a push into an otherwise-empty queue bypasses to the head.
  always_comb begin
    count_next  = count + CW'(accept) - CW'(pop);
    rd_ptr_next = rd_ptr + PW'(pop);
    head_next   = (accept && (wr_ptr == rd_ptr_next)) ? sum : mem[rd_ptr_next];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      addr_out  <= '0;
      carry_out <= 1'b0;
      wrap_seen <= 1'b0;
    end else begin
      if (accept) mem[wr_ptr] <= sum;
      wr_ptr    <= wr_ptr + PW'(accept);
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      in_ready  <= (count_next != FULL);
      out_valid <= (count_next != '0);
      addr_out  <= head_next[WIDTH-1:0];
      carry_out <= head_next[WIDTH];
      if (accept && sum[WIDTH]) wrap_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_addr_gen_pipe.sv
// Bench for addr_gen_pipe: directed vector table, multi-cycle corner sequences and
// random traffic compared against a queue-based arithmetic reference.
module tb_addr_gen_pipe;

  localparam int W = 16;
  localparam int D = 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          in_valid;
  logic          in_ready;
  logic          base_sel;
  logic [1:0]    off_sel;
  logic          zext;
  logic [W-1:0]  PC;
  logic [W-1:0]  BaseR;
  logic [W-1:0]  IR;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  addr_out;
  logic          carry_out;
  logic [$clog2(D):0] count;
  logic          wrap_seen;

  addr_gen_pipe #(
    .WIDTH(W), .OFF_A_W(6), .OFF_B_W(9), .OFF_C_W(11), .DEPTH(D)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .base_sel(base_sel), .off_sel(off_sel), .zext(zext), .PC(PC), .BaseR(BaseR), .IR(IR),
    .out_valid(out_valid), .out_ready(out_ready), .addr_out(addr_out),
    .carry_out(carry_out), .count(count), .wrap_seen(wrap_seen)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          bs;
    logic [1:0]    os;
    logic          z;
    logic [W-1:0]  pc;
    logic [W-1:0]  br;
    logic [W-1:0]  ir;
    logic [W-1:0]  ea;
    logic          ec;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic         c;
  } res_t;

  res_t mq[$];
  bit   sticky;
  bit   armed;
  int   passed;
  int   total;
  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: field value, signed reinterpretation, modular add, carry as overflow past 2^W.
  function automatic res_t ref_calc(input logic bs, input logic [1:0] os, input logic z,
                                    input logic [W-1:0] pc, input logic [W-1:0] br,
                                    input logic [W-1:0] ir);
    longint base, off, s;
    int     w;
    res_t   r;
    base = bs ? longint'(br) : longint'(pc);
    case (os)
      2'd0:    w = 0;
      2'd1:    w = 6;
      2'd2:    w = 9;
      default: w = 11;
    endcase
    off = 0;
    if (w > 0) begin
      off = longint'(ir) % (longint'(1) << w);
      if (!z && off >= (longint'(1) << (w - 1))) off = off - (longint'(1) << w);
    end
    if (off < 0) off = off + (longint'(1) << W);
    s   = base + off;
    r.a = W'(s % (longint'(1) << W));
    r.c = (s >= (longint'(1) << W));
    return r;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".in_ready"},  longint'(in_ready),  longint'(armed && (mq.size() != D)));
    chk({tag, ".out_valid"}, longint'(out_valid), longint'(mq.size() != 0));
    chk({tag, ".count"},     longint'(count),     longint'(mq.size()));
    chk({tag, ".wrap_seen"}, longint'(wrap_seen), longint'(sticky));
    if (mq.size() != 0) begin
      chk({tag, ".addr_out"},  longint'(addr_out),  longint'(mq[0].a));
      chk({tag, ".carry_out"}, longint'(carry_out), longint'(mq[0].c));
    end
  endtask

  // One clock: model decides accept/pop from pre-edge inputs, then outputs checked at negedge.
  task automatic step(input string tag);
    bit   acc, pp;
    res_t r, dummy;
    acc = armed && in_valid && (mq.size() < D);
    pp  = (mq.size() != 0) && out_ready;
    r   = ref_calc(base_sel, off_sel, zext, PC, BaseR, IR);
    @(posedge Clk);
    armed = (Reset_n == 1'b1);
    if (pp) dummy = mq.pop_front();
    if (acc) begin
      mq.push_back(r);
      if (r.c) sticky = 1'b1;
    end
    @(negedge Clk);
    check_state(tag);
  endtask

  task automatic rand_ops();
    base_sel = 1'($urandom);
    off_sel  = 2'($urandom);
    zext     = 1'($urandom);
    PC       = W'($urandom);
    BaseR    = W'($urandom);
    IR       = W'($urandom);
  endtask

  task automatic set_req(input logic bs, input logic [1:0] os, input logic z,
                         input logic [W-1:0] pc, input logic [W-1:0] br, input logic [W-1:0] ir);
    base_sel = bs; off_sel = os; zext = z; PC = pc; BaseR = br; IR = ir;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    mq.delete();
    sticky = 1'b0;
    armed  = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    passed = 0; total = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    set_req(1'b0, 2'b00, 1'b0, '0, '0, '0);

    vecs[0] = '{1'b1, 2'b01, 1'b1, 16'h0000, 16'h1234, 16'h003F, 16'h1273, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 1'b1, 16'h0000, 16'h1234, 16'h003F, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 2'b00, 1'b0, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 1'b0, 16'h0100, 16'h0000, 16'h0400, 16'hFD00, 1'b0};
    vecs[4] = '{1'b0, 2'b11, 1'b1, 16'h0100, 16'h0000, 16'h0400, 16'h0500, 1'b0};
    vecs[5] = '{1'b0, 2'b10, 1'b0, 16'h3000, 16'h0000, 16'h01FF, 16'h2FFF, 1'b1};
    vecs[6] = '{1'b1, 2'b01, 1'b0, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 2'b01, 1'b0, 16'h0000, 16'h0010, 16'h0020, 16'hFFF0, 1'b0};
    vecs[8] = '{1'b0, 2'b10, 1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h81FF, 1'b0};

    // Reset values while held low.
    Reset_n = 1'b0;
    mq.delete(); sticky = 1'b0; armed = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check_state("reset");
    chk("reset.addr_out",  longint'(addr_out),  0);
    chk("reset.carry_out", longint'(carry_out), 0);
    Reset_n = 1'b1;
    step("release");

    // Directed vectors: one request, check head one cycle later with operands scrambled, then pop.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_req(vecs[i].bs, vecs[i].os, vecs[i].z, vecs[i].pc, vecs[i].br, vecs[i].ir);
      in_valid = 1'b1;
      step($sformatf("vec%0d.acc", i));
      in_valid = 1'b0;
      rand_ops();
      chk($sformatf("vec%0d.addr", i),  longint'(addr_out),  longint'(vecs[i].ea));
      chk($sformatf("vec%0d.carry", i), longint'(carry_out), longint'(vecs[i].ec));
      step($sformatf("vec%0d.pop", i));
    end
    chk("sticky.after_table", longint'(wrap_seen), 1);

    // Backpressure: fill, offer a carrying request while full, then drain in order.
    apply_reset();
    step("bp.release");
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      set_req(1'b1, 2'b01, 1'b1, 16'h0000, W'(16'h0100 + i), 16'h0003);
      in_valid = 1'b1;
      step($sformatf("bp.fill%0d", i));
    end
    set_req(1'b1, 2'b01, 1'b0, 16'h0000, 16'hFFFF, 16'h0001);
    step("bp.ignored0");
    step("bp.ignored1");
    chk("bp.count_full", longint'(count), longint'(D));
    chk("bp.no_sticky",  longint'(wrap_seen), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (i == 0) chk("bp.first_head", longint'(addr_out), 64'h0103);
      step($sformatf("bp.drain%0d", i));
    end

    // Simultaneous push and pop at count=1, long enough to wrap the pointers several times.
    out_ready = 1'b0;
    rand_ops();
    in_valid = 1'b1;
    step("sim.seed");
    out_ready = 1'b1;
    for (int i = 0; i < 3 * D; i++) begin
      rand_ops();
      step($sformatf("sim.stream%0d", i));
      chk($sformatf("sim.count%0d", i), longint'(count), 1);
    end
    in_valid = 1'b0;
    step("sim.drain");

    // Reset between edges with two entries queued.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_ops();
      step($sformatf("rst.fill%0d", i));
    end
    #2 Reset_n = 1'b0;
    #1;
    mq.delete(); sticky = 1'b0; armed = 1'b0;
    chk("rst.out_valid", longint'(out_valid), 0);
    chk("rst.count",     longint'(count),     0);
    chk("rst.in_ready",  longint'(in_ready),  0);
    chk("rst.wrap_seen", longint'(wrap_seen), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    set_req(1'b0, 2'b01, 1'b1, 16'h4000, 16'h0000, 16'h0005);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step("rst.first_edge");
    step("rst.accept");
    in_valid = 1'b0;
    chk("rst.first_result", longint'(addr_out), 64'h4005);
    step("rst.pop");

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
